fighting_arena_core: RTL and testbench

- Parametrised two-player fighting core: owns player positions on a line arena, health, attack cooldowns, round scoring and best-of-N match result.
- Next generation of the fixed 3-cell, single-round game: configurable arena size, health, cooldown and rounds; adds defend action, draw handling and an inter-round pause.
- Sits between the action-input front end (buttons / keypad decode) and the display / scoreboard logic.

---
 rtl/fighting_pkg.sv | 17 +
 rtl/fighting_arena_core_fighter_unit.sv | 48 ++++
 rtl/fighting_arena_core.sv | 167 ++++++++++++++++
 tb/tb_fighting_arena_core.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fighting_pkg.sv
// Shared definitions for the two-player fighting core: action encodings and
// the match-level state machine states.
package fighting_pkg;

    localparam logic [2:0] ACT_IDLE   = 3'b000;
    localparam logic [2:0] ACT_LEFT   = 3'b001;
    localparam logic [2:0] ACT_RIGHT  = 3'b010;
    localparam logic [2:0] ACT_ATTACK = 3'b011;
    localparam logic [2:0] ACT_DEFEND = 3'b100;

    typedef enum logic [1:0] {
        FIGHT      = 2'd0,
        ROUND_END  = 2'd1,
        MATCH_OVER = 2'd2
    } arena_state_e;

endpackage

// File: rtl/fighting_arena_core_fighter_unit.sv
// One player's health and attack-cooldown registers; the top instantiates
// it once per player and feeds it the resolved hit/attack for each turn.
module fighter_unit
    import fighting_pkg::*;
#(
    parameter int HEALTH_MAX = 3,
    parameter int COOLDOWN   = 2,
    parameter int HEALTH_W   = 2,
    parameter int CD_W       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                turn,
    input  logic                hit_taken,
    input  logic                attack_attempt,
    input  logic                round_reload,
    output logic [HEALTH_W-1:0] health,
    output logic                cooldown_zero
);

    logic [HEALTH_W-1:0] health_r;
    logic [CD_W-1:0]     cd_r;

    // Health and cooldown update, one step per enabled turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health_r <= HEALTH_W'(HEALTH_MAX);
            cd_r     <= {CD_W{1'b0}};
        end else if (round_reload) begin
            health_r <= HEALTH_W'(HEALTH_MAX);
            cd_r     <= {CD_W{1'b0}};
        end else if (turn) begin
            if (hit_taken && (health_r != {HEALTH_W{1'b0}})) begin
                health_r <= health_r - HEALTH_W'(1);
            end
            // An attack during cooldown is void and only lets the timer run down.
            if (attack_attempt && (cd_r == {CD_W{1'b0}})) begin
                cd_r <= CD_W'(COOLDOWN);
            end else if (cd_r != {CD_W{1'b0}}) begin
                cd_r <= cd_r - CD_W'(1);
            end
        end
    end

    assign health        = health_r;
    assign cooldown_zero = (cd_r == {CD_W{1'b0}});

endmodule

// File: rtl/fighting_arena_core.sv
// Two-player line-arena fighting core: movement arbitration, hit resolution,
// round scoring with an inter-round pause and best-of-N match result.
module fighting_arena_core
    import fighting_pkg::*;
#(
    parameter int NUM_CELLS     = 8,
    parameter int HEALTH_MAX    = 3,
    parameter int COOLDOWN      = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int ROUND_GAP     = 4,
    localparam int POS_W    = $clog2(NUM_CELLS),
    localparam int HEALTH_W = $clog2(HEALTH_MAX + 1),
    localparam int CD_W     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1,
    localparam int RND_W    = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                actionEnable,
    input  logic [2:0]          action1,
    input  logic [2:0]          action2,
    output logic [POS_W-1:0]    pos1,
    output logic [POS_W-1:0]    pos2,
    output logic [HEALTH_W-1:0] health1,
    output logic [HEALTH_W-1:0] health2,
    output logic [RND_W-1:0]    rounds1,
    output logic [RND_W-1:0]    rounds2,
    output logic                roundOver,
    output logic                firstWin,
    output logic                secondWin
);

    localparam int GAP_W = (ROUND_GAP > 1) ? $clog2(ROUND_GAP + 1) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_CELLS - 1);

    arena_state_e        state_r, state_nxt_s;
    logic [POS_W-1:0]    pos1_r, pos2_r, cand1_s, cand2_s;
    logic [HEALTH_W-1:0] h1_s, h2_s;
    logic [RND_W-1:0]    rounds1_r, rounds2_r;
    logic [GAP_W-1:0]    gap_r;
    logic                roundover_r, first_win_r, second_win_r;
    logic                turn_s, adjacent_s, atk1_s, atk2_s, cdz1_s, cdz2_s;
    logic                hit_on1_s, hit_on2_s, dead1_s, dead2_s;
    logic                gap_done_s, win1_s, win2_s, reload_s;

    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                  input logic [2:0] act);
        case (act)
            ACT_LEFT:  step_pos = (p == {POS_W{1'b0}}) ? p : p - POS_W'(1);
            ACT_RIGHT: step_pos = (p == LAST_POS) ? p : p + POS_W'(1);
            default:   step_pos = p;
        endcase
    endfunction

    assign turn_s     = actionEnable && (state_r == FIGHT);
    assign cand1_s    = step_pos(pos1_r, action1);
    assign cand2_s    = step_pos(pos2_r, action2);
    assign adjacent_s = ((pos2_r - pos1_r) == POS_W'(1));
    assign atk1_s     = (action1 == ACT_ATTACK);
    assign atk2_s     = (action2 == ACT_ATTACK);
    assign hit_on2_s  = atk1_s && cdz1_s && adjacent_s && (action2 != ACT_DEFEND);
    assign hit_on1_s  = atk2_s && cdz2_s && adjacent_s && (action1 != ACT_DEFEND);
    // Health never sits at zero during FIGHT, so a hit at 1 is the killing blow.
    assign dead1_s    = hit_on1_s && (h1_s == HEALTH_W'(1));
    assign dead2_s    = hit_on2_s && (h2_s == HEALTH_W'(1));
    assign gap_done_s = (gap_r == GAP_W'(ROUND_GAP - 1));
    assign win1_s     = (rounds1_r == RND_W'(ROUNDS_TO_WIN));
    assign win2_s     = (rounds2_r == RND_W'(ROUNDS_TO_WIN));
    assign reload_s   = (state_r == ROUND_END) && gap_done_s && !(win1_s || win2_s);

    fighter_unit #(.HEALTH_MAX(HEALTH_MAX), .COOLDOWN(COOLDOWN),
                   .HEALTH_W(HEALTH_W), .CD_W(CD_W)) u_fighter1 (
        .clk(clk), .rst_n(resetGame), .turn(turn_s), .hit_taken(hit_on1_s),
        .attack_attempt(atk1_s), .round_reload(reload_s),
        .health(h1_s), .cooldown_zero(cdz1_s)
    );

    fighter_unit #(.HEALTH_MAX(HEALTH_MAX), .COOLDOWN(COOLDOWN),
                   .HEALTH_W(HEALTH_W), .CD_W(CD_W)) u_fighter2 (
        .clk(clk), .rst_n(resetGame), .turn(turn_s), .hit_taken(hit_on2_s),
        .attack_attempt(atk2_s), .round_reload(reload_s),
        .health(h2_s), .cooldown_zero(cdz2_s)
    );

    // Match FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FIGHT: begin
                if (turn_s && (dead1_s || dead2_s)) begin
                    state_nxt_s = ROUND_END;
                end else begin
                    state_nxt_s = FIGHT;
                end
            end
            ROUND_END: begin
                if (gap_done_s) begin
                    state_nxt_s = (win1_s || win2_s) ? MATCH_OVER : FIGHT;
                end else begin
                    state_nxt_s = ROUND_END;
                end
            end
            MATCH_OVER: state_nxt_s = MATCH_OVER;
            default:    state_nxt_s = FIGHT;
        endcase
    end

    // Match FSM state register.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            state_r <= FIGHT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Player positions; a move that would cross or collide cancels both moves.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            pos1_r <= {POS_W{1'b0}};
            pos2_r <= LAST_POS;
        end else if (reload_s) begin
            pos1_r <= {POS_W{1'b0}};
            pos2_r <= LAST_POS;
        end else if (turn_s && (cand1_s < cand2_s)) begin
            pos1_r <= cand1_s;
            pos2_r <= cand2_s;
        end
    end

    // Round scoring, inter-round gap counter and sticky match flags.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            rounds1_r    <= {RND_W{1'b0}};
            rounds2_r    <= {RND_W{1'b0}};
            gap_r        <= {GAP_W{1'b0}};
            roundover_r  <= 1'b0;
            first_win_r  <= 1'b0;
            second_win_r <= 1'b0;
        end else begin
            roundover_r <= (state_nxt_s == ROUND_END);
            gap_r       <= (state_r == ROUND_END) ? gap_r + GAP_W'(1) : {GAP_W{1'b0}};
            if (turn_s && dead2_s && !dead1_s) begin
                rounds1_r <= rounds1_r + RND_W'(1);
            end
            if (turn_s && dead1_s && !dead2_s) begin
                rounds2_r <= rounds2_r + RND_W'(1);
            end
            if ((state_r == ROUND_END) && gap_done_s && win1_s) begin
                first_win_r <= 1'b1;
            end
            if ((state_r == ROUND_END) && gap_done_s && win2_s && !win1_s) begin
                second_win_r <= 1'b1;
            end
        end
    end

    assign pos1      = pos1_r;
    assign pos2      = pos2_r;
    assign health1   = h1_s;
    assign health2   = h2_s;
    assign rounds1   = rounds1_r;
    assign rounds2   = rounds2_r;
    assign roundOver = roundover_r;
    assign firstWin  = first_win_r;
    assign secondWin = second_win_r;

endmodule

// File: tb/tb_fighting_arena_core.sv
// Directed-vector bench for fighting_arena_core with default parameters
// (8 cells, health 3, cooldown 2, two rounds to win, 4-cycle gap).
module tb_fighting_arena_core;

    localparam logic [2:0] IDL = 3'b000;
    localparam logic [2:0] LFT = 3'b001;
    localparam logic [2:0] RGT = 3'b010;
    localparam logic [2:0] ATK = 3'b011;
    localparam logic [2:0] DEF = 3'b100;

    logic       clk = 1'b0;
    logic       resetGame;
    logic       actionEnable;
    logic [2:0] action1, action2;
    logic [2:0] pos1, pos2;
    logic [1:0] health1, health2, rounds1, rounds2;
    logic       roundOver, firstWin, secondWin;

    int total = 0;
    int bad   = 0;

    fighting_arena_core dut (
        .clk(clk), .resetGame(resetGame), .actionEnable(actionEnable),
        .action1(action1), .action2(action2),
        .pos1(pos1), .pos2(pos2), .health1(health1), .health2(health2),
        .rounds1(rounds1), .rounds2(rounds2), .roundOver(roundOver),
        .firstWin(firstWin), .secondWin(secondWin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_arena(input string tag, input int p1, input int p2,
                             input int h1, input int h2);
        chk({tag, ".pos1"}, 32'(pos1), p1);
        chk({tag, ".pos2"}, 32'(pos2), p2);
        chk({tag, ".health1"}, 32'(health1), h1);
        chk({tag, ".health2"}, 32'(health2), h2);
    endtask

    // Called right after a falling edge; returns right after the next one.
    task automatic turn(input logic [2:0] a1, input logic [2:0] a2);
        actionEnable = 1'b1;
        action1      = a1;
        action2      = a2;
        @(negedge clk);
        actionEnable = 1'b0;
        action1      = IDL;
        action2      = IDL;
    endtask

    task automatic approach();
        repeat (3) turn(RGT, LFT);
    endtask

    task automatic p1_kills_p2();
        turn(ATK, IDL);
        turn(IDL, IDL);
        turn(IDL, IDL);
        turn(ATK, IDL);
        turn(IDL, IDL);
        turn(IDL, IDL);
        turn(ATK, IDL);
    endtask

    initial begin
        resetGame    = 1'b0;
        actionEnable = 1'b0;
        action1      = IDL;
        action2      = IDL;
        repeat (2) @(negedge clk);
        resetGame = 1'b1;

        chk_arena("reset", 0, 7, 3, 3);
        chk("reset.rounds1", 32'(rounds1), 0);
        chk("reset.rounds2", 32'(rounds2), 0);
        chk("reset.roundOver", 32'(roundOver), 0);
        chk("reset.firstWin", 32'(firstWin), 0);
        chk("reset.secondWin", 32'(secondWin), 0);

        turn(RGT, LFT);
        chk_arena("move1", 1, 6, 3, 3);
        turn(RGT, LFT);
        turn(RGT, LFT);
        chk_arena("move3", 3, 4, 3, 3);
        turn(RGT, LFT);
        chk_arena("blocked", 3, 4, 3, 3);
        turn(3'b111, 3'b101);
        chk_arena("unused_codes", 3, 4, 3, 3);

        turn(ATK, IDL);
        chk_arena("hit1", 3, 4, 3, 2);
        turn(ATK, IDL);
        chk_arena("cooldown_void", 3, 4, 3, 2);
        turn(IDL, IDL);
        turn(ATK, IDL);
        chk_arena("hit_after_cd", 3, 4, 3, 1);

        turn(IDL, IDL);
        turn(IDL, IDL);
        turn(ATK, DEF);
        chk_arena("defended", 3, 4, 3, 1);
        turn(ATK, IDL);
        chk_arena("defend_cd_loaded", 3, 4, 3, 1);
        turn(IDL, IDL);

        turn(IDL, ATK);
        chk_arena("p2_hit1", 3, 4, 2, 1);
        turn(IDL, IDL);
        turn(IDL, IDL);
        turn(IDL, ATK);
        chk_arena("p2_hit2", 3, 4, 1, 1);
        turn(IDL, IDL);
        turn(IDL, IDL);

        turn(ATK, ATK);
        chk_arena("draw", 3, 4, 0, 0);
        chk("draw.roundOver0", 32'(roundOver), 1);
        chk("draw.rounds1", 32'(rounds1), 0);
        chk("draw.rounds2", 32'(rounds2), 0);
        for (int i = 1; i < 4; i++) begin
            turn(RGT, LFT);
            chk($sformatf("draw.roundOver%0d", i), 32'(roundOver), 1);
        end
        @(negedge clk);
        chk("draw.gap_end", 32'(roundOver), 0);
        chk_arena("draw.reload", 0, 7, 3, 3);

        approach();
        p1_kills_p2();
        chk("r1.rounds1", 32'(rounds1), 1);
        chk("r1.rounds2", 32'(rounds2), 0);
        chk("r1.roundOver", 32'(roundOver), 1);
        chk_arena("r1.end", 3, 4, 3, 0);
        repeat (4) turn(RGT, LFT);
        chk("r1.gap_end", 32'(roundOver), 0);
        chk_arena("r1.reload", 0, 7, 3, 3);

        approach();
        p1_kills_p2();
        chk("r2.rounds1", 32'(rounds1), 2);
        chk("r2.firstWin_early", 32'(firstWin), 0);
        repeat (4) @(negedge clk);
        chk("match.firstWin", 32'(firstWin), 1);
        chk("match.secondWin", 32'(secondWin), 0);
        chk("match.roundOver", 32'(roundOver), 0);
        turn(RGT, LFT);
        turn(ATK, ATK);
        chk_arena("match.frozen", 3, 4, 3, 0);
        chk("match.rounds1", 32'(rounds1), 2);
        chk("match.firstWin_held", 32'(firstWin), 1);
        chk("match.secondWin_held", 32'(secondWin), 0);

        resetGame = 1'b0;
        @(negedge clk);
        resetGame = 1'b1;
        chk("rst2.firstWin", 32'(firstWin), 0);
        chk("rst2.rounds1", 32'(rounds1), 0);
        approach();
        p1_kills_p2();
        chk("gap_rst.roundOver_pre", 32'(roundOver), 1);
        @(negedge clk);
        #2;
        resetGame = 1'b0;
        #1;
        chk_arena("gap_rst.async", 0, 7, 3, 3);
        chk("gap_rst.rounds1", 32'(rounds1), 0);
        chk("gap_rst.roundOver", 32'(roundOver), 0);
        #1;
        resetGame = 1'b1;
        @(negedge clk);
        turn(RGT, IDL);
        chk_arena("gap_rst.next_turn", 1, 7, 3, 3);
        chk("gap_rst.roundOver_after", 32'(roundOver), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
